rt2_fp_sched: RTL
=================

Name: rt2_fp_sched

Overview:
- Shares one iterative divide/square-root unit (rt2_fp) between NREQ issue ports using round-robin arbitration.
- Sequences each operation: waits for unit ready, drives start, selects per-precision step count, tags the operation, then returns the completion to the owning port with backpressure.
- Sits between the FP issue ports and rt2_fp. The operand mux is external and is steered by unit_sel.

Parameters:
- NREQ, 2: number of requesting ports (2..4).
- TAG_W, 9: width of the per-operation tag.
- STEP_D, 13: step_cnt for type 0 (double).
- STEP_S, 6: step_cnt for type 1 (single).
- STEP_X, 16: step_cnt for type 2 (extended); types 3..7 use STEP_D.
- WDOG, 255: maximum number of BUSY cycles before abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  port i has an operation
- req_ready  out  NREQ  one-hot grant; handshake completes on valid&ready
- req_is_root  in  NREQ  1=sqrt, 0=divide
- req_type  in  3*NREQ  precision type, port i at [3i+2:3i]
- req_rmode  in  3*NREQ  rounding mode
- req_tag  in  TAG_W*NREQ  operation tag
- flush  in  1  cancel the in-flight operation
- unit_rdy  in  1  rt2_fp idle and able to accept
- unit_start  out  1  start_process to rt2_fp
- unit_sel  out  NREQ  one-hot operand mux select (valid while unit_start)
- unit_is_root  out  1  to rt2_fp is_root
- unit_type  out  3  to rt2_fp type
- unit_rmode  out  3  to rt2_fp rmode
- unit_step_cnt  out  5  to rt2_fp step_cnt
- unit_out_en  in  1  rt2_fp result valid
- unit_out_can  out  1  to rt2_fp out_can (result may leave)
- res_valid  out  1  completion valid; result data is taken from rt2_fp directly
- res_port  out  NREQ  one-hot owning port
- res_tag  out  TAG_W  tag of completing operation
- res_ready  in  1  consumer accepts completion
- wdog_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, cnt=0, tag_q=0, port_q=0.
- Reset values of outputs: req_ready=0, unit_start=0, unit_sel=0, unit_out_can=0, res_valid=0, res_port=0, res_tag=0, wdog_err=0.
- Reset mid-operation abandons the operation; no completion is produced.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - Grant g is the first port with req_valid set, searching from rr_ptr upward with wrap-around.
  - A grant issues only if unit_rdy=1 and flush=0. Then, combinationally in the same cycle: req_ready[g]=1, unit_start=1, unit_sel=onehot(g), unit_is_root/type/rmode=fields of port g, unit_step_cnt from type(g).
  - On issue register: tag_q=req_tag[g], port_q=onehot(g), rr_ptr=(g+1) mod NREQ, cnt=0, next state BUSY.
  - With no grant, all unit_* control outputs are 0 (unit_step_cnt=0).
- BUSY:
  - cnt increments each cycle, saturating.
  - unit_out_can=res_ready.
  - res_valid=unit_out_en; res_tag=tag_q; res_port=port_q.
  - unit_out_en & res_ready: completion accepted, next state IDLE.
  - flush (priority over completion): res_valid forced 0, next state DRAIN.
  - cnt reaches WDOG with no unit_out_en: wdog_err=1 for one cycle, next state DRAIN.
- DRAIN:
  - unit_out_can=1, res_valid=0.
  - Leaves for IDLE on unit_out_en, or when unit_rdy=1 with no out_en (unit already idle).
- Issue rate: no new grant in the completion cycle. Back-to-back latency is at least one IDLE cycle.
- Latency from request to completion is set by the unit; the scheduler adds 0 cycles on issue and 0 on completion.
- flush in IDLE: suppresses grant that cycle only.
- req_valid dropped without grant: no state change.

Test Plan:
- Single port 0 divide, type 0, unit_rdy=1 -> same-cycle req_ready=01, unit_start=1, unit_step_cnt=13; on unit_out_en, res_valid=1, res_tag=request tag, res_port=01.
- Both ports valid continuously, 4 operations -> grants alternate 01,10,01,10; no port starved.
- res_ready=0 for 5 cycles while unit_out_en=1 -> unit_out_can=0, res_valid held with stable tag; returns to IDLE the cycle res_ready=1.
- flush asserted in BUSY -> no res_valid for that op; DRAIN holds unit_out_can=1; next request issues after unit_out_en.
- Unit never asserts out_en, WDOG=255 -> wdog_err pulses exactly once at cnt=255, state returns to IDLE once unit_rdy=1.
- type 1 sqrt / type 2 / type 5 -> unit_step_cnt 6 / 16 / 13, unit_is_root=1 for sqrt. rst pulse mid-BUSY -> all outputs 0 immediately and rr_ptr=0.

Source files
------------

// File: rtl/rt2_fp_sched.sv
// rtl/rt2_fp_sched.sv - round-robin scheduler sharing one rt2_fp divide/sqrt unit
module rt2_fp_sched #(
  parameter int NREQ   = 2,
  parameter int TAG_W  = 9,
  parameter int STEP_D = 13,
  parameter int STEP_S = 6,
  parameter int STEP_X = 16,
  parameter int WDOG   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_is_root,
  input  logic [3*NREQ-1:0]     req_type,
  input  logic [3*NREQ-1:0]     req_rmode,
  input  logic [TAG_W*NREQ-1:0] req_tag,
  input  logic                  flush,
  input  logic                  unit_rdy,
  output logic                  unit_start,
  output logic [NREQ-1:0]       unit_sel,
  output logic                  unit_is_root,
  output logic [2:0]            unit_type,
  output logic [2:0]            unit_rmode,
  output logic [4:0]            unit_step_cnt,
  input  logic                  unit_out_en,
  output logic                  unit_out_can,
  output logic                  res_valid,
  output logic [NREQ-1:0]       res_port,
  output logic [TAG_W-1:0]      res_tag,
  input  logic                  res_ready,
  output logic                  wdog_err
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WDOG + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_rr_ptr;
  logic [CW-1:0]    r_cnt;
  logic [TAG_W-1:0] r_tag_q;
  logic [NREQ-1:0]  r_port_q;

  logic             w_found;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_cand;
  logic [NREQ-1:0]  w_gsel;
  logic [2:0]       w_gtype;
  logic [4:0]       w_step;
  logic [PW-1:0]    w_rr_next;
  logic             w_issue;
  logic             w_busy;
  logic             w_wdog;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = PW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  assign w_gsel    = w_found ? (NREQ'(1) << w_gidx) : '0;
  assign w_gtype   = req_type[3*int'(w_gidx) +: 3];
  assign w_rr_next = PW'((int'(w_gidx) + 1) % NREQ);

  always_comb begin
    w_step = 5'(STEP_D);
    case (w_gtype)
      3'd1:    w_step = 5'(STEP_S);
      3'd2:    w_step = 5'(STEP_X);
      default: w_step = 5'(STEP_D);
    endcase
  end

  // Reset gates the issue path so no grant leaks out while rst is held.
  assign w_issue = (r_state == IDLE) && w_found && unit_rdy && !flush && !rst;
  assign w_busy  = (r_state == BUSY);
  assign w_wdog  = w_busy && !flush && !unit_out_en && (r_cnt >= CW'(WDOG));

  assign req_ready     = w_issue ? w_gsel : '0;
  assign unit_start    = w_issue;
  assign unit_sel      = w_issue ? w_gsel : '0;
  assign unit_is_root  = w_issue & req_is_root[w_gidx];
  assign unit_type     = w_issue ? w_gtype : 3'd0;
  assign unit_rmode    = w_issue ? req_rmode[3*int'(w_gidx) +: 3] : 3'd0;
  assign unit_step_cnt = w_issue ? w_step : 5'd0;

  assign unit_out_can  = (r_state == DRAIN) || (w_busy && res_ready);
  assign res_valid     = w_busy && unit_out_en && !flush;
  assign res_port      = w_busy ? r_port_q : '0;
  assign res_tag       = w_busy ? r_tag_q : '0;
  assign wdog_err      = w_wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_tag_q  <= '0;
      r_port_q <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_tag_q  <= req_tag[TAG_W*int'(w_gidx) +: TAG_W];
            r_port_q <= w_gsel;
            r_rr_ptr <= w_rr_next;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (flush)                         r_state <= DRAIN;
          else if (unit_out_en && res_ready) r_state <= IDLE;
          else if (w_wdog)                   r_state <= DRAIN;
        end
        DRAIN: begin
          // The unit either flushes its stale result out or is already idle.
          if (unit_out_en || unit_rdy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
